wb_ram_arbiter: RTL and testbench
=================================

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM word-address width.
REQ-002 SHALL have port wb_clk_i  input  1  single clock for both Wishbone ports and the RAM.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports wbs_a_stb_i, wbs_a_cyc_i, wbs_a_we_i  input  1 each  Wishbone classic slave A controls.
REQ-005 SHALL have ports wbs_a_sel_i  input  4, wbs_a_dat_i  input  32, wbs_a_adr_i  input  ADDR_WIDTH+2  (byte address).
REQ-006 SHALL have ports wbs_a_ack_o  output  1, wbs_a_dat_o  output  32.
REQ-007 SHALL have the same set for port B (wbs_b_*), with identical widths.
REQ-008 SHALL have ports ram_clk0  output  1; ram_csb0, ram_web0  output  1 (active low); ram_wmask0  output  4; ram_addr0  output  ADDR_WIDTH; ram_din0  output  32; ram_dout0  input  32.
REQ-009 SHALL have port grant_o  output  2  one-hot owner of the current transaction (bit0=A, bit1=B), 0 when idle.

Function
REQ-010 SHALL drive ram_clk0 = wb_clk_i.
REQ-011 SHALL treat a port as requesting when cyc_i & stb_i is high while the FSM is in IDLE.
REQ-012 SHALL implement FSM states IDLE, RUN, ACK; IDLE->RUN on any request; RUN->ACK unconditionally; ACK->IDLE unconditionally.
REQ-013 SHALL, on IDLE->RUN, register from the granted port: ram_addr0 = adr_i[ADDR_WIDTH+1:2], ram_din0 = dat_i, ram_wmask0 = sel_i if we_i else 4'b0000, ram_web0 = ~we_i, and set ram_csb0 = 0.
REQ-014 SHALL hold ram_csb0 = 0 for exactly the RUN cycle; ram_csb0 = 1, ram_web0 = 1, ram_wmask0 = 0 in IDLE and ACK.
REQ-015 SHALL assert the granted port's ack_o for exactly the ACK cycle (registered), and only if that port's cyc_i is still high.
REQ-016 SHALL drive the granted port's dat_o = ram_dout0 during ACK; dat_o SHALL be 0 for the non-granted port and for all ports outside ACK.
REQ-017 SHALL give a latency of request at cycle N -> csb0 low at N+1 -> ack at N+2; throughput one transaction per 3 cycles.
REQ-018 SHALL, when both ports request in the same IDLE cycle, grant the port not granted last (round-robin); a single requester is always granted.
REQ-019 SHALL update the last-granted record only on IDLE->RUN.
REQ-020 SHALL complete the RAM access if the granted master drops cyc_i during RUN (a write still occurs), suppress ack per REQ-015, and return to IDLE.
REQ-021 SHALL never assert the non-granted port's ack_o; a waiting master stays stalled with no timeout.
REQ-022 SHALL hold grant_o one-hot during RUN and ACK, and 0 in IDLE.

Reset
REQ-023 SHALL, on wb_rst_i high at a clock edge (including mid-RUN/ACK), go to IDLE with ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, ack_o=0 on both ports, grant_o=0.
REQ-024 SHALL reset last-granted to B, so A wins the first simultaneous request.

Configuration
REQ-025 SHALL support macro WB_RAM_ARB_FIXED_PRIO_EN: defined -> port A always wins simultaneous requests and REQ-018/REQ-024 round-robin is not compiled in; undefined -> round-robin per REQ-018.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, RUN, ACK) and port index constants (PORT_A=0, PORT_B=1) in package wb_ram_arb_pkg.
REQ-027 SHALL use one sub-module, rr_arbiter2: two request inputs, a one-hot grant output, an advance strobe, and a last-grant register; it also contains the fixed-priority variant.

Verification
REQ-028 SHALL cover: reset, then an A write at adr 0x010 with dat 0xDEADBEEF and sel 4'hF -> csb0=0, web0=0, addr0=4, wmask0=F at N+1; a_ack at N+2.
REQ-029 SHALL cover: a B read at adr 0x010 -> b_ack at N+2 with b_dat_o=0xDEADBEEF, a_dat_o=0.
REQ-030 SHALL cover: A and B both requesting at every opportunity for 4 transactions -> grants A,B,A,B (with WB_RAM_ARB_FIXED_PRIO_EN: A,A,A,A while A keeps requesting).
REQ-031 SHALL cover: A write with sel 4'b0010 -> wmask0=0010; a read-back shows only byte 1 changed.
REQ-032 SHALL cover: A drops cyc during RUN -> write occurs, no a_ack, FSM in IDLE at N+3.
REQ-033 SHALL cover: wb_rst_i asserted during RUN -> next cycle csb0=1, grant_o=0, no ack on either port.

Source files
------------

// File: rtl/wb_ram_arb_pkg.sv
// Shared types and constants for the two-port Wishbone RAM arbiter.
// Optional build macro: WB_RAM_ARB_FIXED_PRIO_EN selects fixed A-first priority.
package wb_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  function automatic logic [1:0] port_onehot(input int port);
    return (port == PORT_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// Wishbone classic slave-side bundle for one arbiter port.
interface wb_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic [31:0]           dat_w;
  logic [ADDR_WIDTH+1:0] adr;
  logic                  ack;
  logic [31:0]           dat_r;

  modport master (output cyc, stb, we, sel, dat_w, adr, input  ack, dat_r);
  modport slave  (input  cyc, stb, we, sel, dat_w, adr, output ack, dat_r);

endinterface

// File: rtl/wb_ram_arbiter_rr_arbiter2.sv
// Two-requester arbiter: round-robin by default, fixed A-first priority
// when WB_RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
  import wb_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef WB_RAM_ARB_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk, srst, advance};

  always_comb begin
    grant = 2'b00;
    if (req[PORT_A])      grant = port_onehot(PORT_A);
    else if (req[PORT_B]) grant = port_onehot(PORT_B);
  end

`else

  // last_q: 1 means B owned the previous transaction, so A wins the next tie.
  logic last_q;
  logic last_d;

  always_comb begin
    grant = 2'b00;
    if (req[PORT_A] && req[PORT_B])
      grant = last_q ? port_onehot(PORT_A) : port_onehot(PORT_B);
    else if (req[PORT_A])
      grant = port_onehot(PORT_A);
    else if (req[PORT_B])
      grant = port_onehot(PORT_B);
  end

  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00))
      last_d = grant[PORT_B];
  end

  always_ff @(posedge clk) begin
    if (srst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

`endif

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two Wishbone classic slaves sharing one single-port RAM, 3-cycle transactions.
// Build macro WB_RAM_ARB_FIXED_PRIO_EN: port A always wins simultaneous requests.
module wb_ram_arbiter
  import wb_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_dat_i,
  input  logic [ADDR_WIDTH+1:0] wbs_a_adr_i,
  output logic                  wbs_a_ack_o,
  output logic [31:0]           wbs_a_dat_o,

  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_dat_i,
  input  logic [ADDR_WIDTH+1:0] wbs_b_adr_i,
  output logic                  wbs_b_ack_o,
  output logic [31:0]           wbs_b_dat_o,

  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_din0,
  input  logic [31:0]           ram_dout0,

  output logic [1:0]            grant_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_ACK  = ACK;

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;

  logic [1:0]            req;
  logic [1:0]            arb_grant;
  logic                  advance;
  logic                  pick_b;
  logic [ADDR_WIDTH+1:0] sel_adr;

  logic unused_adr;
  assign unused_adr = ^{wbs_a_adr_i[1:0], wbs_b_adr_i[1:0]};

  assign req     = {wbs_b_cyc_i & wbs_b_stb_i, wbs_a_cyc_i & wbs_a_stb_i}
                 & {2{state_q == S_IDLE}};
  assign advance = (state_q == S_IDLE) && (req != 2'b00);
  assign pick_b  = arb_grant[PORT_B];
  assign sel_adr = pick_b ? wbs_b_adr_i : wbs_a_adr_i;

  rr_arbiter2 u_arb (
    .clk     (wb_clk_i),
    .srst    (wb_rst_i),
    .req     (req),
    .advance (advance),
    .grant   (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = 4'b0000;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (advance) begin
          state_d = S_RUN;
          grant_d = arb_grant;
          csb_d   = 1'b0;
          addr_d  = sel_adr[ADDR_WIDTH+1:2];
          if (pick_b) begin
            din_d   = wbs_b_dat_i;
            web_d   = ~wbs_b_we_i;
            wmask_d = wbs_b_we_i ? wbs_b_sel_i : 4'b0000;
          end else begin
            din_d   = wbs_a_dat_i;
            web_d   = ~wbs_a_we_i;
            wmask_d = wbs_a_we_i ? wbs_a_sel_i : 4'b0000;
          end
        end
      end
      S_RUN: begin
        // The RAM access completes regardless; the ack is only owed to a master still in its cycle.
        state_d = S_ACK;
        ack_a_d = grant_q[PORT_A] & wbs_a_cyc_i;
        ack_b_d = grant_q[PORT_B] & wbs_b_cyc_i;
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= 4'b0000;
      addr_q  <= '0;
      din_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  assign ram_clk0    = wb_clk_i;
  assign ram_csb0    = csb_q;
  assign ram_web0    = web_q;
  assign ram_wmask0  = wmask_q;
  assign ram_addr0   = addr_q;
  assign ram_din0    = din_q;
  assign grant_o     = grant_q;
  assign wbs_a_ack_o = ack_a_q;
  assign wbs_b_ack_o = ack_b_q;
  assign wbs_a_dat_o = ((state_q == S_ACK) && grant_q[PORT_A]) ? ram_dout0 : 32'h0;
  assign wbs_b_dat_o = ((state_q == S_ACK) && grant_q[PORT_B]) ? ram_dout0 : 32'h0;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_wb_ram_arbiter;

  localparam int AW = 8;

  typedef struct {
    int          port;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_clk0, ram_csb0, ram_web0;
  logic [3:0]    ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [31:0]   ram_din0;
  logic [31:0]   ram_dout0 = 32'h0;
  logic [1:0]    grant_o;

  logic [31:0]   ram_mem [256];
  logic [31:0]   exp_mem [256];
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;

  wb_ram_arbiter_if #(.ADDR_WIDTH(AW)) a_if ();
  wb_ram_arbiter_if #(.ADDR_WIDTH(AW)) b_if ();

  always #5 clk = ~clk;

  wb_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_a_stb_i (a_if.stb),
    .wbs_a_cyc_i (a_if.cyc),
    .wbs_a_we_i  (a_if.we),
    .wbs_a_sel_i (a_if.sel),
    .wbs_a_dat_i (a_if.dat_w),
    .wbs_a_adr_i (a_if.adr),
    .wbs_a_ack_o (a_if.ack),
    .wbs_a_dat_o (a_if.dat_r),
    .wbs_b_stb_i (b_if.stb),
    .wbs_b_cyc_i (b_if.cyc),
    .wbs_b_we_i  (b_if.we),
    .wbs_b_sel_i (b_if.sel),
    .wbs_b_dat_i (b_if.dat_w),
    .wbs_b_adr_i (b_if.adr),
    .wbs_b_ack_o (b_if.ack),
    .wbs_b_dat_o (b_if.dat_r),
    .ram_clk0    (ram_clk0),
    .ram_csb0    (ram_csb0),
    .ram_web0    (ram_web0),
    .ram_wmask0  (ram_wmask0),
    .ram_addr0   (ram_addr0),
    .ram_din0    (ram_din0),
    .ram_dout0   (ram_dout0),
    .grant_o     (grant_o)
  );

  // Single-port RAM: byte-masked write, registered read of the pre-write word.
  always @(posedge ram_clk0) begin
    if (!ram_csb0) begin
      if (!ram_web0)
        for (int b = 0; b < 4; b++)
          if (ram_wmask0[b]) ram_mem[ram_addr0][8*b +: 8] <= ram_din0[8*b +: 8];
      ram_dout0 <= ram_mem[ram_addr0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic port_ack(input int p);
    return (p == 1) ? b_if.ack : a_if.ack;
  endfunction

  function automatic logic [31:0] port_dat(input int p);
    return (p == 1) ? b_if.dat_r : a_if.dat_r;
  endfunction

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_port(input int p, input logic on, input logic we,
                          input logic [AW+1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (p == 1) begin
      b_if.cyc = on; b_if.stb = on; b_if.we = we; b_if.adr = adr; b_if.dat_w = dat; b_if.sel = sel;
    end else begin
      a_if.cyc = on; a_if.stb = on; a_if.we = we; a_if.adr = adr; a_if.dat_w = dat; a_if.sel = sel;
    end
  endtask

  // Drive a request and record what the ack cycle must show.
  task automatic issue(input int p, input logic we, input logic [AW+1:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input logic expect_ack);
    exp_t e;
    logic [AW-1:0] wa;
    wa = adr[AW+1:2];
    set_port(p, 1'b1, we, adr, dat, sel);
    e.port = p;
    e.chk_data = !we;
    e.data = exp_mem[wa];
    if (expect_ack) sb.push_back(e);
    if (we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) exp_mem[wa][8*b +: 8] = dat[8*b +: 8];
  endtask

  task automatic check_ack_phase();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("ack_p%0d", e.port), {31'd0, port_ack(e.port)}, 32'd1);
      check($sformatf("noack_p%0d", 1 - e.port), {31'd0, port_ack(1 - e.port)}, 32'd0);
      if (e.chk_data)
        check($sformatf("rdata_p%0d", e.port), port_dat(e.port), e.data);
      check($sformatf("zero_dat_p%0d", 1 - e.port), port_dat(1 - e.port), 32'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_csb"}, {31'd0, ram_csb0}, 32'd1);
    check({tag, "_grant"}, {30'd0, grant_o}, 32'd0);
    check({tag, "_acks"}, {30'd0, b_if.ack, a_if.ack}, 32'd0);
  endtask

  task automatic single(input int p, input logic we, input logic [AW+1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    logic [AW+1:0] a;
    a = adr;
    @(negedge clk);
    issue(p, we, adr, dat, sel, 1'b1);
    @(negedge clk);
    check("run_csb", {31'd0, ram_csb0}, 32'd0);
    check("run_web", {31'd0, ram_web0}, {31'd0, ~we});
    check("run_addr", {24'd0, ram_addr0}, {24'd0, a[AW+1:2]});
    check("run_wmask", {28'd0, ram_wmask0}, we ? {28'd0, sel} : 32'd0);
    if (we) check("run_din", ram_din0, dat);
    check("run_grant", {30'd0, grant_o}, {30'd0, oh(p)});
    @(negedge clk);
    check_ack_phase();
    set_port(p, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    @(negedge clk);
    check_idle("post_txn");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    set_port(0, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    set_port(1, 1'b0, 1'b0, '0, 32'd0, 4'd0);

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_web", {31'd0, ram_web0}, 32'd1);
    check("reset_wmask", {28'd0, ram_wmask0}, 32'd0);
    check("reset_addr", {24'd0, ram_addr0}, 32'd0);
    check("reset_din", ram_din0, 32'd0);
    check("reset_dat", a_if.dat_r | b_if.dat_r, 32'd0);
    rst = 1'b0;

    // Basic write then cross-port read
    single(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    single(1, 1'b0, 10'h010, 32'h0, 4'hF);

    // Byte-masked write and read-back
    single(0, 1'b1, 10'h020, 32'h11223344, 4'hF);
    single(0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0010);
    single(0, 1'b0, 10'h020, 32'h0, 4'hF);
    check("bytemask_model", exp_mem[8], 32'h1122CC44);

    // Contention: both ports request continuously after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1'b0, 10'h010, 32'h0, 4'hF, 1'b0);
    issue(1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      int ep;
`ifdef WB_RAM_ARB_FIXED_PRIO_EN
      ep = 0;
`else
      ep = k % 2;
`endif
      e.port = ep;
      e.chk_data = 1'b1;
      e.data = (ep == 1) ? exp_mem[8] : exp_mem[4];
      sb.push_back(e);
      @(negedge clk);
      check($sformatf("rr_grant%0d", k), {30'd0, grant_o}, {30'd0, oh(ep)});
      @(negedge clk);
      check_ack_phase();
      if (k == 3) begin
        set_port(0, 1'b0, 1'b0, '0, 32'd0, 4'd0);
        set_port(1, 1'b0, 1'b0, '0, 32'd0, 4'd0);
      end
      @(negedge clk);
      check($sformatf("rr_idle%0d", k), {30'd0, grant_o}, 32'd0);
    end

    // A drops cyc during RUN: write lands, no ack, IDLE at N+3
    @(negedge clk);
    issue(0, 1'b1, 10'h030, 32'h0BADF00D, 4'hF, 1'b0);
    @(negedge clk);
    check("drop_run_csb", {31'd0, ram_csb0}, 32'd0);
    set_port(0, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    @(negedge clk);
    check("drop_no_ack", {30'd0, b_if.ack, a_if.ack}, 32'd0);
    @(negedge clk);
    check_idle("drop_idle");
    single(1, 1'b0, 10'h030, 32'h0, 4'hF);

    // Reset during RUN
    @(negedge clk);
    set_port(1, 1'b1, 1'b1, 10'h040, 32'h12345678, 4'hF);
    @(negedge clk);
    check("rst_run_csb", {31'd0, ram_csb0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    check("rst_mid_addr", {24'd0, ram_addr0}, 32'd0);
    check("rst_mid_din", ram_din0, 32'd0);
    check("rst_mid_wmask", {20'd0, ram_wmask0, 7'd0, ram_web0}, 32'd1);
    set_port(1, 1'b0, 1'b0, '0, 32'd0, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_after");
    single(0, 1'b0, 10'h010, 32'h0, 4'hF);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
